// File: rtl/hazard_scoreboard_if.sv
// Decode/execute hazard bus between the core pipeline (master) and the
// register scoreboard (slave).
interface hazard_scoreboard_if #(
    parameter int NREG = 32,
    parameter int AW   = 5
);
    logic            issue_valid_D;
    logic [1:0]      op_class_D;
    logic            reg_write_D;
    logic [AW-1:0]   wr_reg_D;
    logic [AW-1:0]   rs_D;
    logic [AW-1:0]   rt_D;
    logic            use_rs_D;
    logic            use_rt_D;
    logic            flush_E;
    logic [AW-1:0]   rs_E;
    logic [AW-1:0]   rt_E;
    logic [AW-1:0]   write_reg_M;
    logic [AW-1:0]   write_reg_W;
    logic            reg_write_M;
    logic            reg_write_W;
    logic            stall_D;
    logic [1:0]      forward_a_E;
    logic [1:0]      forward_b_E;
    logic [NREG-1:0] busy_mask;
    logic [31:0]     stall_count;

    modport master (
        output issue_valid_D, op_class_D, reg_write_D, wr_reg_D,
        output rs_D, rt_D, use_rs_D, use_rt_D, flush_E,
        output rs_E, rt_E, write_reg_M, write_reg_W, reg_write_M, reg_write_W,
        input  stall_D, forward_a_E, forward_b_E, busy_mask, stall_count
    );

    modport slave (
        input  issue_valid_D, op_class_D, reg_write_D, wr_reg_D,
        input  rs_D, rt_D, use_rs_D, use_rt_D, flush_E,
        input  rs_E, rt_E, write_reg_M, write_reg_W, reg_write_M, reg_write_W,
        output stall_D, forward_a_E, forward_b_E, busy_mask, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register in-flight write scoreboard: decode stall (RAW/WAW),
// execute-stage forwarding selects and squash of a flushed producer.
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 2,
    parameter int MUL_LAT  = 4,
    parameter int CW       = 3
) (
    input logic               clk,
    input logic               rst,
    hazard_scoreboard_if.slave sb
);

    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_LOAD = 2'd1,
        CLS_MUL  = 2'd2,
        CLS_NONE = 2'd3
    } op_class_t;

    localparam logic [CW-1:0] ALU_M1  = CW'(ALU_LAT - 1);
    localparam logic [CW-1:0] LOAD_M1 = CW'(LOAD_LAT - 1);
    localparam logic [CW-1:0] MUL_M1  = CW'(MUL_LAT - 1);

    logic [CW-1:0]   cnt [1:NREG-1];
    logic [NREG-1:0] busy;
    logic [AW-1:0]   last_dst;
    logic            last_set;
    logic [31:0]     stall_count;

    op_class_t       cls;
    logic [CW-1:0]   lat_m1;
    logic [CW-1:0]   wr_cnt;
    logic            raw_rs;
    logic            raw_rt;
    logic            waw;
    logic            stall;
    logic            issue_fire;
    logic            issue_load;

    assign cls = op_class_t'(sb.op_class_D);

    // Load value for the decode instruction's class; non-writing class uses ALU timing for WAW
    always_comb begin
        lat_m1 = ALU_M1;
        case (cls)
            CLS_LOAD: lat_m1 = LOAD_M1;
            CLS_MUL:  lat_m1 = MUL_M1;
            default:  lat_m1 = ALU_M1;
        endcase
    end

    // Busy vector and the counter of the decode destination register
    always_comb begin
        busy   = '0;
        wr_cnt = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            busy[r] = (cnt[r] != '0);
            if (sb.wr_reg_D == AW'(r)) wr_cnt = cnt[r];
        end
    end

    // Decode hazard detection and issue qualification
    always_comb begin
        raw_rs     = sb.use_rs_D && (sb.rs_D != '0) && busy[sb.rs_D];
        raw_rt     = sb.use_rt_D && (sb.rt_D != '0) && busy[sb.rt_D];
        waw        = sb.reg_write_D && (sb.wr_reg_D != '0) && (wr_cnt > lat_m1);
        stall      = sb.issue_valid_D && !sb.flush_E && (raw_rs || raw_rt || waw);
        issue_fire = sb.issue_valid_D && !stall && !sb.flush_E;
        issue_load = issue_fire && sb.reg_write_D && (sb.wr_reg_D != '0) && (cls != CLS_NONE);
    end

    // Counter update: load beats squash beats decrement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 1; r < NREG; r++) cnt[r] <= '0;
        end else begin
            for (int unsigned r = 1; r < NREG; r++) begin
                if (issue_load && (sb.wr_reg_D == AW'(r)))
                    cnt[r] <= lat_m1;
                else if (sb.flush_E && last_set && (last_dst == AW'(r)))
                    cnt[r] <= '0;
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - CW'(1);
            end
        end
    end

    // Remember the most recent producer so a flush next cycle can forget it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_dst <= '0;
            last_set <= 1'b0;
        end else if (issue_load) begin
            last_dst <= sb.wr_reg_D;
            last_set <= (lat_m1 != '0);
        end else begin
            last_set <= 1'b0;
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count <= '0;
        else if (stall && (stall_count != '1))
            stall_count <= stall_count + 32'd1;
    end

    // Execute-stage forwarding: M has priority over W, r0 never forwards
    always_comb begin
        sb.forward_a_E = 2'b00;
        sb.forward_b_E = 2'b00;
        if (sb.reg_write_M && (sb.write_reg_M != '0) && (sb.write_reg_M == sb.rs_E))
            sb.forward_a_E = 2'b10;
        else if (sb.reg_write_W && (sb.write_reg_W != '0) && (sb.write_reg_W == sb.rs_E))
            sb.forward_a_E = 2'b01;
        if (sb.reg_write_M && (sb.write_reg_M != '0) && (sb.write_reg_M == sb.rt_E))
            sb.forward_b_E = 2'b10;
        else if (sb.reg_write_W && (sb.write_reg_W != '0) && (sb.write_reg_W == sb.rt_E))
            sb.forward_b_E = 2'b01;
    end

    assign sb.stall_D     = stall;
    assign sb.busy_mask   = busy;
    assign sb.stall_count = stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: reset, ALU/load/MUL dependencies,
// WAW ordering, flush squash, r0 handling and forwarding priority.
module tb_hazard_scoreboard;

    localparam int NREG = 32;
    localparam int AW   = 5;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    hazard_scoreboard_if #(.NREG(NREG), .AW(AW)) bus ();

    hazard_scoreboard #(
        .NREG(NREG), .AW(AW), .ALU_LAT(1), .LOAD_LAT(2), .MUL_LAT(4), .CW(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sb (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs are driven 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid_D = 1'b0;
        bus.op_class_D    = 2'd3;
        bus.reg_write_D   = 1'b0;
        bus.wr_reg_D      = '0;
        bus.rs_D          = '0;
        bus.rt_D          = '0;
        bus.use_rs_D      = 1'b0;
        bus.use_rt_D      = 1'b0;
        bus.flush_E       = 1'b0;
    endtask

    task automatic issue_wr(input logic [1:0] cls, input logic [AW-1:0] wr);
        idle();
        bus.issue_valid_D = 1'b1;
        bus.op_class_D    = cls;
        bus.reg_write_D   = 1'b1;
        bus.wr_reg_D      = wr;
    endtask

    task automatic issue_rd(input logic urs, input logic [AW-1:0] rs,
                            input logic urt, input logic [AW-1:0] rt);
        idle();
        bus.issue_valid_D = 1'b1;
        bus.use_rs_D      = urs;
        bus.rs_D          = rs;
        bus.use_rt_D      = urt;
        bus.rt_D          = rt;
    endtask

    task automatic clear_fwd();
        bus.rs_E        = '0;
        bus.rt_E        = '0;
        bus.write_reg_M = '0;
        bus.write_reg_W = '0;
        bus.reg_write_M = 1'b0;
        bus.reg_write_W = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        idle();
        clear_fwd();
        rst = 1'b1;
        #3;
        check("rst_stall", 64'(bus.stall_D), 64'd0);
        check("rst_busy", 64'(bus.busy_mask), 64'd0);
        check("rst_count", 64'(bus.stall_count), 64'd0);
        check("rst_fwd", 64'({bus.forward_a_E, bus.forward_b_E}), 64'd0);
        step();
        rst = 1'b0;
        step();

        // ALU producer then dependent: no stall, M forwarding
        issue_wr(2'd0, 5'd3);
        #1 check("alu_issue_stall", 64'(bus.stall_D), 64'd0);
        step();
        check("alu_busy", 64'(bus.busy_mask), 64'd0);
        issue_rd(1'b1, 5'd3, 1'b0, 5'd0);
        bus.rs_E = 5'd3; bus.write_reg_M = 5'd3; bus.reg_write_M = 1'b1;
        #1 check("alu_use_stall", 64'(bus.stall_D), 64'd0);
        check("alu_fwd_a", 64'(bus.forward_a_E), 64'b10);
        step();
        clear_fwd();

        // Load-use: exactly one stall
        issue_wr(2'd1, 5'd8);
        step();
        check("load_busy", 64'(bus.busy_mask), 64'h100);
        issue_rd(1'b0, 5'd0, 1'b1, 5'd8);
        #1 check("load_use_stall", 64'(bus.stall_D), 64'd1);
        step();
        check("load_use_count", 64'(bus.stall_count), 64'd1);
        check("load_use_release", 64'(bus.stall_D), 64'd0);
        step();

        // MUL-use: three stalls
        issue_wr(2'd2, 5'd9);
        step();
        check("mul_busy", 64'(bus.busy_mask), 64'h200);
        issue_rd(1'b1, 5'd9, 1'b0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("mul_use_stall%0d", i), 64'(bus.stall_D), 64'd1);
            step();
        end
        check("mul_use_release", 64'(bus.stall_D), 64'd0);
        step();
        check("mul_use_count", 64'(bus.stall_count), 64'd4);

        // WAW: ALU write behind MUL write to the same register
        issue_wr(2'd2, 5'd9);
        step();
        issue_wr(2'd0, 5'd9);
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("waw_stall%0d", i), 64'(bus.stall_D), 64'd1);
            step();
        end
        check("waw_release", 64'(bus.stall_D), 64'd0);
        step();
        check("waw_count", 64'(bus.stall_count), 64'd7);

        // MUL behind MUL needs no WAW stall; counter drains by one per cycle
        issue_wr(2'd2, 5'd9);
        step();
        issue_wr(2'd2, 5'd9);
        #1 check("waw_mul_mul", 64'(bus.stall_D), 64'd0);
        step();
        idle();
        step();
        step();
        check("drain_mid", 64'(bus.busy_mask), 64'h200);
        step();
        check("drain_done", 64'(bus.busy_mask), 64'd0);

        // Flush squashes last producer and blocks the decode issue
        issue_wr(2'd1, 5'd4);
        step();
        issue_wr(2'd1, 5'd6);
        bus.use_rs_D = 1'b1; bus.rs_D = 5'd4; bus.flush_E = 1'b1;
        #1 check("flush_stall", 64'(bus.stall_D), 64'd0);
        step();
        check("flush_busy", 64'(bus.busy_mask), 64'd0);
        issue_wr(2'd2, 5'd4);
        step();
        idle();
        bus.flush_E = 1'b1;
        step();
        idle();
        check("flush_mul_busy", 64'(bus.busy_mask), 64'd0);
        check("flush_count", 64'(bus.stall_count), 64'd7);

        // r0 is never tracked
        issue_wr(2'd2, 5'd0);
        step();
        check("r0_busy", 64'(bus.busy_mask), 64'd0);
        issue_rd(1'b1, 5'd0, 1'b1, 5'd0);
        #1 check("r0_read_stall", 64'(bus.stall_D), 64'd0);
        step();
        idle();

        // Forwarding priority
        bus.rs_E = 5'd7; bus.rt_E = 5'd7;
        bus.write_reg_M = 5'd7; bus.write_reg_W = 5'd7;
        bus.reg_write_M = 1'b1; bus.reg_write_W = 1'b1;
        #1 check("fwd_double_a", 64'(bus.forward_a_E), 64'b10);
        check("fwd_double_b", 64'(bus.forward_b_E), 64'b10);
        bus.reg_write_M = 1'b0;
        #1 check("fwd_w_a", 64'(bus.forward_a_E), 64'b01);
        bus.rt_E = 5'd2;
        #1 check("fwd_none_b", 64'(bus.forward_b_E), 64'b00);
        bus.rs_E = 5'd0; bus.write_reg_W = 5'd0;
        #1 check("fwd_r0_a", 64'(bus.forward_a_E), 64'b00);
        clear_fwd();
        step();

        // Asynchronous reset in the middle of a stall
        issue_wr(2'd2, 5'd5);
        step();
        issue_rd(1'b1, 5'd5, 1'b0, 5'd0);
        #1 check("pre_rst_stall_a", 64'(bus.stall_D), 64'd1);
        step();
        issue_wr(2'd2, 5'd5);
        #1 check("rewrite_no_waw", 64'(bus.stall_D), 64'd0);
        step();
        issue_rd(1'b1, 5'd5, 1'b0, 5'd0);
        #1 check("pre_rst_stall_b", 64'(bus.stall_D), 64'd1);
        check("pre_rst_busy", 64'(bus.busy_mask), 64'h20);
        check("pre_rst_count", 64'(bus.stall_count), 64'd8);
        #1 rst = 1'b1;
        #1 check("mid_rst_stall", 64'(bus.stall_D), 64'd0);
        check("mid_rst_busy", 64'(bus.busy_mask), 64'd0);
        check("mid_rst_count", 64'(bus.stall_count), 64'd0);
        step();
        rst = 1'b0;
        idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
